// File: rtl/gf_inv_seq.sv
// gf_inv_seq: GF(2^m) inversion by square-and-multiply, driving an external multiplier via start/done.
module gf_inv_seq #(
  parameter int NUM_BITS = 163,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS:0]   A,
  output logic [NUM_BITS:0]   Result,
  output logic                busy,
  output logic                done,
  output logic                m_start,
  output logic [NUM_BITS:0]   m_A,
  output logic [NUM_BITS:0]   m_B,
  input  logic [NUM_BITS:0]   m_product,
  input  logic                m_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_SQ_ISSUE, S_SQ_WAIT, S_MUL_ISSUE, S_MUL_WAIT, S_DONE
  } state_t;
  state_t state, nxt;
  logic [NUM_BITS:0] s, r, s_nxt, r_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last;
  assign last = cnt == CNT_W'(NUM_BITS - 1);
  always_comb begin
    nxt     = state;
    s_nxt   = s;
    r_nxt   = r;
    cnt_nxt = cnt;
    case (state)
      S_IDLE: if (start) begin
        nxt     = S_SQ_ISSUE;
        s_nxt   = A;
        r_nxt   = (NUM_BITS + 1)'(1);
        cnt_nxt = CNT_W'(1);
      end
      S_SQ_ISSUE:  nxt = S_SQ_WAIT;
      S_SQ_WAIT: if (m_done) begin
        s_nxt = m_product;
        nxt   = S_MUL_ISSUE;
      end
      S_MUL_ISSUE: nxt = S_MUL_WAIT;
      S_MUL_WAIT: if (m_done) begin
        r_nxt   = m_product;
        nxt     = last ? S_DONE : S_SQ_ISSUE;
        cnt_nxt = last ? cnt : cnt + CNT_W'(1);
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with the state they belong to
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      s       <= '0;
      r       <= '0;
      cnt     <= '0;
      Result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      m_start <= 1'b0;
      m_A     <= '0;
      m_B     <= '0;
    end else begin
      state   <= nxt;
      s       <= s_nxt;
      r       <= r_nxt;
      cnt     <= cnt_nxt;
      done    <= nxt == S_DONE;
      busy    <= nxt != S_IDLE;
      m_start <= nxt == S_SQ_ISSUE || nxt == S_MUL_ISSUE;
      if (nxt == S_SQ_ISSUE) begin
        m_A <= s_nxt;
        m_B <= s_nxt;
      end else if (nxt == S_MUL_ISSUE) begin
        m_A <= r_nxt;
        m_B <= s_nxt;
      end
      if (nxt == S_DONE) Result <= r_nxt;
    end
  end
endmodule

// File: tb/tb_gf_inv_seq.sv
// tb_gf_inv_seq: drives gf_inv_seq with a behavioural variable-latency GF(2^163) multiplier.
module tb_gf_inv_seq;
  localparam logic [327:0] POLY = (328'd1 << 163) | 328'hC9;
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [163:0] A = '0;
  logic [163:0] Result, m_A, m_B, m_product;
  logic         busy, done, m_start, m_done;
  int tests = 0, fails = 0;
  int lat_fixed = 3, lat_cur = 1, mstarts = 0, stab_err = 0, mleft = 0;
  logic         mbusy;
  logic [163:0] opa, opb;

  gf_inv_seq dut (
    .clk(clk), .n_rst(n_rst), .start(start), .A(A), .Result(Result),
    .busy(busy), .done(done), .m_start(m_start), .m_A(m_A), .m_B(m_B),
    .m_product(m_product), .m_done(m_done)
  );

  always #5 clk = ~clk;

  // polynomial product followed by reduction modulo x^163+x^7+x^6+x^3+1
  function automatic logic [163:0] gf_mul(input logic [163:0] a, input logic [163:0] b);
    logic [327:0] p;
    p = '0;
    for (int i = 0; i < 164; i++) if (b[i]) p = p ^ ({164'b0, a} << i);
    for (int i = 327; i >= 163; i--) if (p[i]) p = p ^ (POLY << (i - 163));
    return p[163:0];
  endfunction

  function automatic logic [163:0] rnd_a();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w[191:163] = '0;
    if (w == '0) w[0] = 1'b1;
    return w[163:0];
  endfunction

  // multiplier model: latency L counted from the m_start cycle to the m_done cycle
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mbusy  <= 1'b0;
      m_done <= 1'b0;
      mleft  <= 0;
      opa    <= '0;
      opb    <= '0;
      m_product <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_start) mstarts <= mstarts + 1;
      if (mbusy) begin
        if (m_A !== opa || m_B !== opb) stab_err <= stab_err + 1;
        if (mleft == 1) begin
          m_done    <= 1'b1;
          m_product <= gf_mul(opa, opb);
          mbusy     <= 1'b0;
        end else mleft <= mleft - 1;
      end else if (m_start) begin
        opa     <= m_A;
        opb     <= m_B;
        lat_cur <= int'($urandom_range(8, 1));
        if ((lat_fixed != 0 ? lat_fixed : lat_cur) == 1) begin
          m_done    <= 1'b1;
          m_product <= gf_mul(m_A, m_B);
        end else begin
          mbusy <= 1'b1;
          mleft <= (lat_fixed != 0 ? lat_fixed : lat_cur) - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where done is seen (or budget runs out)
  task automatic run_inv(input logic [163:0] a, input bit poke, input logic [163:0] poke_a,
                         output logic [163:0] res, output int cyc, output int nm);
    int m0;
    m0 = mstarts;
    start = 1'b1;
    A = a;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chki("busy_after_accept", int'(busy), 1);
    while (!done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 200) begin
        start = 1'b1;
        A = poke_a;
      end else start = 1'b0;
    end
    start = 1'b0;
    chki("done_seen", int'(done), 1);
    chki("busy_at_done", int'(busy), 1);
    res = Result;
    nm = mstarts - m0;
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chki({tag, "_done_dropped"}, int'(done), 0);
    chki({tag, "_busy_dropped"}, int'(busy), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_Result"}, Result, '0);
    chk({tag, "_m_A"}, m_A, '0);
    chk({tag, "_m_B"}, m_B, '0);
    chki({tag, "_busy"}, int'(busy), 0);
    chki({tag, "_done"}, int'(done), 0);
    chki({tag, "_m_start"}, int'(m_start), 0);
  endtask

  initial begin
    logic [163:0] res, a, a2, inv2;
    int cyc, nm, m0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("after_release");

    lat_fixed = 3;
    run_inv(164'h1, 1'b0, '0, res, cyc, nm);
    chk("inv_of_1", res, 164'h1);
    chki("latency_L3", cyc, 1297);
    chki("mstarts_L3", nm, 324);
    post_idle("one");

    inv2 = '0;
    inv2[162] = 1'b1;
    inv2[6] = 1'b1;
    inv2[5] = 1'b1;
    inv2[2] = 1'b1;
    lat_fixed = 1;
    run_inv(164'h2, 1'b0, '0, res, cyc, nm);
    chk("inv_of_x", res, inv2);
    chk("x_times_inv", gf_mul(164'h2, res), 164'h1);
    chki("latency_L1", cyc, 1 + 324 * 2);
    post_idle("x");

    lat_fixed = 0;
    for (int i = 0; i < 20; i++) begin
      a = rnd_a();
      run_inv(a, 1'b0, '0, res, cyc, nm);
      chk("rand_a_times_inv", gf_mul(a, res), 164'h1);
      chki("rand_mstarts", nm, 324);
      post_idle("rand");
    end

    run_inv('0, 1'b0, '0, res, cyc, nm);
    chk("inv_of_0", res, '0);
    post_idle("zero");

    a = rnd_a();
    a2 = rnd_a();
    run_inv(a, 1'b1, a2, res, cyc, nm);
    chk("ignored_restart_inv", gf_mul(a, res), 164'h1);
    chki("ignored_restart_mstarts", nm, 324);
    a = rnd_a();
    @(negedge clk);
    run_inv(a, 1'b0, '0, res, cyc, nm);
    chk("back_to_back_inv", gf_mul(a, res), 164'h1);
    post_idle("b2b");

    lat_fixed = 2;
    m0 = mstarts;
    start = 1'b1;
    A = rnd_a();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5000 && mstarts - m0 < 100; i++) @(negedge clk);
    chki("reached_mult_100", mstarts - m0, 100);
    #2 n_rst = 1'b0;
    #1 chk_zero_outputs("midop_reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    lat_fixed = 0;
    a = rnd_a();
    run_inv(a, 1'b0, '0, res, cyc, nm);
    chk("after_reset_inv", gf_mul(a, res), 164'h1);
    chki("after_reset_mstarts", nm, 324);
    post_idle("final");

    chki("operands_stable_in_wait", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gf_inv_seq.md
# gf_inv_seq

GF(2^163) inversion sequencer that drives an external `gf_Mult` multiplier over its start/done handshake. It is the initiator end of that interface: it issues operand pairs, waits for `done`, captures `Product`, and repeats. It computes A^-1 = A^(2^163 - 2) by repeated square-and-multiply. It sits between the ECC point-arithmetic control and the shared multiplier instance.

## Interface
- `NUM_BITS`, 163, field degree m. All field ports are [NUM_BITS:0], 164 bits wide. Bit NUM_BITS is always 0 in legal operands.
- `CNT_W`, 8, iteration counter width. Must satisfy 2^CNT_W > NUM_BITS.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request inversion of `A`; sampled only in IDLE.
- `A`  in  164  operand; captured on the accepted `start` edge.
- `Result`  out  164  A^-1; valid from the `done` pulse until the next accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `m_start`  out  1  one-cycle start pulse to the multiplier.
- `m_A`, `m_B`  out  164  multiplier operands; stable from the `m_start` cycle until `m_done`.
- `m_product`  in  164  multiplier result; sampled only when `m_done` is high.
- `m_done`  in  1  multiplier completion; treated as a pulse.

## Operation
Registers:
- `s`: running square, initialised to A.
- `r`: running product, initialised to 164'h1.
- `cnt`: iteration counter, 1..NUM_BITS-1.

Algorithm: for i = 1..NUM_BITS-1, first s ← s·s, then r ← r·s. Final r = A^(2^1 + ... + 2^(m-1)) = A^-1.

States:
- IDLE: `start` high → load s=A, r=1, cnt=1, go to SQ_ISSUE. Otherwise stay.
- SQ_ISSUE: m_start=1, m_A=m_B=s. Go to SQ_WAIT.
- SQ_WAIT: on m_done, s ← m_product, go to MUL_ISSUE.
- MUL_ISSUE: m_start=1, m_A=r, m_B=s. Go to MUL_WAIT.
- MUL_WAIT: on m_done, r ← m_product.
  - If cnt == NUM_BITS-1, go to DONE.
  - Otherwise cnt ← cnt+1, go to SQ_ISSUE.
- DONE: done=1, Result=r (registered output). Go to IDLE.

Rules:
- `m_A`/`m_B` are registered and held constant throughout each WAIT state.
- `m_done` outside a WAIT state is ignored.
- `start` while not in IDLE is ignored; A is not recaptured.
- A=0 yields Result=0. This is undefined mathematically but deterministic. No error flag.
- Bit NUM_BITS of A is not checked; it is passed through to the multiplier unchanged.

## Timing
Reset values:
- state=IDLE.
- `Result`=0, `done`=0, `busy`=0, `m_start`=0, `m_A`=0, `m_B`=0.
- s, r, cnt = 0.

Handshake and latency:
- Multiplier latency L is the number of cycles from the `m_start` cycle to the `m_done` cycle, with L ≥ 1.
- Each multiplication costs L+1 cycles (issue cycle + wait). The next `m_start` follows the capturing edge by exactly 1 cycle.
- Total multiplications: 2·(NUM_BITS-1) = 324 `m_start` pulses per inversion.
- `start` accepted at edge k → `done` high at cycle k + 1 + 324·(L+1).
- `busy` is low in IDLE. It may be low in the `done` cycle's successor, so back-to-back `start` is accepted the cycle after `done`.

Boundary conditions:
- `m_done` in the same cycle as `m_start`: must not occur (L ≥ 1). If it does, it is ignored.
- `n_rst` low mid-operation: immediately returns to IDLE with all outputs at reset values. An in-flight multiplier result is dropped; the multiplier is reset by the same `n_rst`.
- `start` and `n_rst` deasserting in the same cycle: `start` is ignored until the first edge after reset release.

## Test plan
- A=164'h1, behavioural multiplier with L=3 → Result=164'h1. Exactly 324 `m_start` pulses. `done` exactly 1+324·4 = 1297 cycles after start.
- A=164'h2 (x), field polynomial x^163+x^7+x^6+x^3+1 → Result has only bits 162, 6, 5, 2 set. Bench checks that A·Result = 1 with the reference model.
- Random nonzero A (×20), L randomised per multiplication (1..8) → A·Result = 1. `m_A`/`m_B` never change while in a WAIT state.
- A=0 → Result=0, `done` pulses once, `busy` drops.
- `start` pulsed again with a different A mid-operation → ignored; Result is the inverse of the first A. Then back-to-back `start` the cycle after `done` → accepted.
- `n_rst` asserted during the 100th multiplication → all outputs 0 within the same cycle. A fresh `start` after release completes correctly.
